imm_sel_ctrl: RTL and testbench
===============================

IMM_SEL_CTRL -- requirements
Module: imm_sel_ctrl

Interface
REQ-001 The block SHALL have parameter ILL_CNT_W, default 8, setting the width of the illegal-opcode counter.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports IN_VALID (input, 1), IN_READY (output, 1), IN_INSTR (input, 32) and IN_PC (input, 32), forming the IF/ID-side instruction handshake.
REQ-005 The block SHALL have ports OUT_VALID (output, 1) and OUT_READY (input, 1), forming the EX-side handshake.
REQ-006 The block SHALL have ports OUT_INSTR (output, 32) and OUT_PC (output, 32), holding the instruction and PC at the head of the buffer.
REQ-007 The block SHALL have port IMM_PICK, output, 3, the immediate-format select for the head instruction: 000 I, 001 S, 010 U, 011 B, 100 J.
REQ-008 The block SHALL have port USES_IMM, output, 1, asserted when the head instruction consumes an immediate.
REQ-009 The block SHALL have port ILLEGAL, output, 1, asserted when the head opcode is unrecognised.
REQ-010 The block SHALL have port FLUSH, input, 1, which discards all buffered instructions.
REQ-011 The block SHALL have port ILL_COUNT, output, ILL_CNT_W, present only with the configuration macro defined.

Function
REQ-012 The block SHALL decode opcode bits [6:0]:
- I: 0000011, 0001111, 0010011, 1100111, 1110011
- S: 0100011
- U: 0110111, 0010111
- B: 1100011
- J: 1101111
REQ-013 Opcode 0110011 (R-type, including M-extension) SHALL give IMM_PICK 000, USES_IMM 0 and ILLEGAL 0.
REQ-014 Any other opcode SHALL give IMM_PICK 111, USES_IMM 0 and ILLEGAL 1.
REQ-015 Decode SHALL be performed at capture and stored with the entry, so IMM_PICK, USES_IMM and ILLEGAL are registered outputs.
REQ-016 Storage SHALL be a two-entry FIFO (head plus skid), and the FSM SHALL have states EMPTY, ONE and TWO.
REQ-017 IN_READY SHALL be a registered output, equal to 1 in EMPTY and ONE and 0 in TWO.
REQ-018 An instruction SHALL be accepted when IN_VALID and IN_READY are both 1, and popped when OUT_VALID and OUT_READY are both 1.
REQ-019 OUT_VALID SHALL be 1 in ONE and TWO and 0 in EMPTY.
REQ-020 FSM transitions SHALL be:
- EMPTY + accept -> ONE.
- ONE + accept + no pop -> TWO.
- ONE + pop + no accept -> EMPTY.
- ONE + accept + pop -> ONE, with the new instruction at the head.
- TWO + pop -> ONE, with the skid entry promoted to head.
- Otherwise the state holds.
REQ-021 Latency from accept in EMPTY to OUT_VALID SHALL be 1 cycle.
REQ-022 Program order SHALL be preserved, with no drops or duplicates.
REQ-023 While OUT_VALID=1 and OUT_READY=0, OUT_INSTR, OUT_PC, IMM_PICK, USES_IMM and ILLEGAL SHALL remain stable.
REQ-024 FLUSH=1 SHALL force EMPTY on the next edge and discard any instruction offered in the same cycle; FLUSH has priority over accept and pop.
REQ-025 After a flush, IN_READY SHALL be 1 and OUT_VALID SHALL be 0 on the following cycle.

Reset
REQ-026 RESET=1 at a rising edge SHALL force EMPTY, OUT_VALID 0, IN_READY 1, OUT_INSTR 0, OUT_PC 0, IMM_PICK 000, USES_IMM 0, ILLEGAL 0 and ILL_COUNT 0.
REQ-027 RESET SHALL take priority over FLUSH, accept and pop, including mid-transfer; buffered instructions are lost.

Configuration
REQ-028 When macro IMM_SEL_ILL_COUNT_EN is defined, ILL_COUNT SHALL increment by 1 on each pop of an entry with ILLEGAL=1.
REQ-029 ILL_COUNT SHALL saturate at all-ones, and flushed entries SHALL NOT be counted.
REQ-030 When IMM_SEL_ILL_COUNT_EN is undefined, the ILL_COUNT port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover: reset, then IN_INSTR=0x00500093 (addi) accepted -> next cycle OUT_VALID=1, IMM_PICK=000, USES_IMM=1, OUT_INSTR=0x00500093.
REQ-032 The bench SHALL cover: OUT_READY=0 with sw 0x00112623, then beq 0x00208463 accepted -> state TWO, IN_READY=0, head IMM_PICK=001 stable; after OUT_READY=1, pops occur in order with IMM_PICK 001 then 011.
REQ-033 The bench SHALL cover: streaming lui 0x123452B7 and jal 0x008000EF with OUT_READY=1 held -> one instruction per cycle, IMM_PICK 010 then 100, IN_READY held at 1.
REQ-034 The bench SHALL cover: FLUSH=1 in state TWO together with IN_VALID=1 -> next cycle OUT_VALID=0 and IN_READY=1, and the offered instruction never appears at the output.
REQ-035 The bench SHALL cover: add 0x002081B3 -> USES_IMM=0, ILLEGAL=0; opcode 0x0000007F -> ILLEGAL=1, IMM_PICK=111; with the macro, ILL_COUNT=1 after the pop, and with ILL_CNT_W=2 it saturates at 3.
REQ-036 The bench SHALL cover: RESET=1 asserted in state TWO with OUT_READY=1 -> next cycle all outputs at the REQ-026 values and no pop occurs.

Source files
------------

// File: rtl/imm_sel_ctrl.sv
// imm_sel_ctrl: two-entry (head + skid) instruction buffer that pre-decodes the RISC-V immediate format.
// Latency: 1 cycle from accept into an empty buffer to OUT_VALID; decode is stored with each entry.
// Backpressure: IN_READY drops only when both entries are full; OUT_READY=0 holds the head stable.
// Optional: define IMM_SEL_ILL_COUNT_EN to add the saturating ILL_COUNT port.
module imm_sel_ctrl #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [31:0]          IN_INSTR,
  input  logic [31:0]          IN_PC,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [31:0]          OUT_INSTR,
  output logic [31:0]          OUT_PC,
  output logic [2:0]           IMM_PICK,
  output logic                 USES_IMM,
  output logic                 ILLEGAL,
  input  logic                 FLUSH
`ifdef IMM_SEL_ILL_COUNT_EN
  ,
  output logic [ILL_CNT_W-1:0] ILL_COUNT
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // One buffered instruction together with its pre-computed decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  pick;
    logic        uses;
    logic        ill;
  } entry_t;

  state_t r_state;
  logic   r_in_ready;
  logic   r_out_valid;
  entry_t r_hd;
  entry_t r_sk;
  entry_t w_new;
  logic   w_acc;
  logic   w_pop;

  assign w_acc = IN_VALID & r_in_ready;
  assign w_pop = r_out_valid & OUT_READY;

  // Decode the incoming opcode so the stored entry carries its immediate format.
  always_comb begin
    w_new.instr = IN_INSTR;
    w_new.pc    = IN_PC;
    w_new.pick  = 3'b111;
    w_new.uses  = 1'b0;
    w_new.ill   = 1'b1;
    case (IN_INSTR[6:0])
      7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011: begin
        w_new.pick = 3'b000; w_new.uses = 1'b1; w_new.ill = 1'b0;
      end
      7'b0100011: begin
        w_new.pick = 3'b001; w_new.uses = 1'b1; w_new.ill = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        w_new.pick = 3'b010; w_new.uses = 1'b1; w_new.ill = 1'b0;
      end
      7'b1100011: begin
        w_new.pick = 3'b011; w_new.uses = 1'b1; w_new.ill = 1'b0;
      end
      7'b1101111: begin
        w_new.pick = 3'b100; w_new.uses = 1'b1; w_new.ill = 1'b0;
      end
      // R-type (incl. M-extension) is legal but has no immediate.
      7'b0110011: begin
        w_new.pick = 3'b000; w_new.uses = 1'b0; w_new.ill = 1'b0;
      end
      default: ;
    endcase
  end

  // Occupancy FSM: reset beats flush, flush beats accept/pop; handshake flags are registered with the state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_hd        <= '0;
      r_sk        <= '0;
    end else if (FLUSH) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_hd        <= w_new;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_acc && !w_pop) begin
            r_sk       <= w_new;
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_pop && !w_acc) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end else if (w_acc && w_pop) begin
            r_hd <= w_new;
          end
        end
        TWO: begin
          // IN_READY is low here, so only a pop can happen.
          if (w_pop) begin
            r_hd       <= r_sk;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT_INSTR = r_hd.instr;
  assign OUT_PC    = r_hd.pc;
  assign IMM_PICK  = r_hd.pick;
  assign USES_IMM  = r_hd.uses;
  assign ILLEGAL   = r_hd.ill;

`ifdef IMM_SEL_ILL_COUNT_EN
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  // Count popped illegal entries, saturating; a flush suppresses the pop so flushed entries never count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ill_cnt <= '0;
    end else if (!FLUSH && w_pop && r_hd.ill && (r_ill_cnt != '1)) begin
      r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
    end
  end

  assign ILL_COUNT = r_ill_cnt;
`endif

endmodule

// File: tb/tb_imm_sel_ctrl.sv
// tb_imm_sel_ctrl: directed scenarios followed by random traffic against a queue-based reference model.
// Latency: the model predicts the buffer contents one edge at a time; a negedge monitor compares.
// Backpressure: OUT_READY, FLUSH and RESET are exercised directly and randomly.
module tb_imm_sel_ctrl;

  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          IN_VALID;
  logic          IN_READY;
  logic [31:0]   IN_INSTR;
  logic [31:0]   IN_PC;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [31:0]   OUT_INSTR;
  logic [31:0]   OUT_PC;
  logic [2:0]    IMM_PICK;
  logic          USES_IMM;
  logic          ILLEGAL;
  logic          FLUSH;
`ifdef IMM_SEL_ILL_COUNT_EN
  logic [CW-1:0] ILL_COUNT;
`endif

  imm_sel_ctrl #(.ILL_CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INSTR(IN_INSTR), .IN_PC(IN_PC),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC),
    .IMM_PICK(IMM_PICK), .USES_IMM(USES_IMM), .ILLEGAL(ILLEGAL), .FLUSH(FLUSH)
`ifdef IMM_SEL_ILL_COUNT_EN
    , .ILL_COUNT(ILL_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t exp_q[$];
  int    exp_cnt  = 0;
  bit    exp_zero = 1'b0;
  bit    mon_en   = 1'b0;
  int    checks   = 0;
  int    errors   = 0;

  // Reference decode straight from the opcode table.
  function automatic void ref_decode(input logic [31:0] instr, output logic [2:0] pick,
                                     output logic uses, output logic ill);
    logic [6:0] op;
    op   = instr[6:0];
    pick = 3'b111; uses = 1'b0; ill = 1'b1;
    if (op inside {7'h03, 7'h0F, 7'h13, 7'h67, 7'h73}) begin pick = 3'd0; uses = 1'b1; ill = 1'b0; end
    else if (op == 7'h23)                 begin pick = 3'd1; uses = 1'b1; ill = 1'b0; end
    else if (op inside {7'h37, 7'h17})    begin pick = 3'd2; uses = 1'b1; ill = 1'b0; end
    else if (op == 7'h63)                 begin pick = 3'd3; uses = 1'b1; ill = 1'b0; end
    else if (op == 7'h6F)                 begin pick = 3'd4; uses = 1'b1; ill = 1'b0; end
    else if (op == 7'h33)                 begin pick = 3'd0; uses = 1'b0; ill = 1'b0; end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted instructions, capacity two.
  always @(posedge CLK) begin
    bit          pop, acc;
    logic [2:0]  p;
    logic        u, il;
    if (RESET) begin
      exp_q.delete();
      exp_cnt  = 0;
      exp_zero = 1'b1;
    end else if (FLUSH) begin
      exp_q.delete();
    end else begin
      pop = (exp_q.size() > 0) && OUT_READY;
      acc = IN_VALID && (exp_q.size() < 2);
      if (pop) begin
        ref_decode(exp_q[0].instr, p, u, il);
        if (il && exp_cnt < (1 << CW) - 1) exp_cnt++;
        void'(exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back('{IN_INSTR, IN_PC});
        exp_zero = 1'b0;
      end
    end
  end

  // Monitor: compare handshake flags and the head entry against the model every cycle.
  always @(negedge CLK) begin
    logic [2:0] p;
    logic       u, il;
    if (mon_en) begin
      chk("in_ready", 32'(IN_READY), 32'(exp_q.size() < 2));
      chk("out_valid", 32'(OUT_VALID), 32'(exp_q.size() > 0));
      if (OUT_VALID && exp_q.size() > 0) begin
        ref_decode(exp_q[0].instr, p, u, il);
        chk("out_instr", OUT_INSTR, exp_q[0].instr);
        chk("out_pc", OUT_PC, exp_q[0].pc);
        chk("imm_pick", 32'(IMM_PICK), 32'(p));
        chk("uses_imm", 32'(USES_IMM), 32'(u));
        chk("illegal", 32'(ILLEGAL), 32'(il));
      end else if (exp_zero) begin
        chk("rst_instr", OUT_INSTR, 32'h0);
        chk("rst_pc", OUT_PC, 32'h0);
        chk("rst_fields", {27'h0, IMM_PICK, USES_IMM, ILLEGAL}, 32'h0);
      end
`ifdef IMM_SEL_ILL_COUNT_EN
      chk("ill_count", 32'(ILL_COUNT), 32'(exp_cnt));
`endif
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    IN_VALID = 1'b1; IN_INSTR = instr; IN_PC = pc;
  endtask

  initial begin
    logic [31:0] ins;
    RESET = 1'b1; IN_VALID = 1'b0; IN_INSTR = '0; IN_PC = '0; OUT_READY = 1'b0; FLUSH = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    RESET = 1'b0;

    // addi into an empty buffer, visible the next cycle
    OUT_READY = 1'b1; offer(32'h00500093, 32'h100); tick();
    IN_VALID = 1'b0; tick(); tick();

    // sw then beq stall in the buffer, then drain in order
    OUT_READY = 1'b0; offer(32'h00112623, 32'h104); tick();
    offer(32'h00208463, 32'h108); tick();
    offer(32'h00000013, 32'h10C); tick(); tick();
    IN_VALID = 1'b0; OUT_READY = 1'b1; tick(); tick(); tick();

    // lui / jal streaming with OUT_READY held high
    offer(32'h123452B7, 32'h200); tick();
    offer(32'h008000EF, 32'h204); tick();
    IN_VALID = 1'b0; tick(); tick();

    // flush while full, with a new instruction offered in the same cycle
    OUT_READY = 1'b0; offer(32'h00300113, 32'h300); tick();
    offer(32'h00400193, 32'h304); tick();
    offer(32'hDEADB037, 32'h308); FLUSH = 1'b1; tick();
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; tick(); tick();

    // R-type, then illegal opcodes until the counter saturates
    offer(32'h002081B3, 32'h400); tick();
    for (int i = 0; i < 5; i++) begin
      offer(32'h0000007F | (32'(i) << 12), 32'h404 + 32'(4 * i)); tick();
    end
    IN_VALID = 1'b0; tick(); tick();

    // reset while full and OUT_READY high: nothing pops
    OUT_READY = 1'b0; offer(32'h0000007F, 32'h500); tick();
    offer(32'h00112623, 32'h504); tick();
    IN_VALID = 1'b0; OUT_READY = 1'b1; RESET = 1'b1; tick();
    RESET = 1'b0; tick(); tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      ins = $urandom();
      case ($urandom_range(0, 11))
        0:  ins[6:0] = 7'h03;
        1:  ins[6:0] = 7'h13;
        2:  ins[6:0] = 7'h23;
        3:  ins[6:0] = 7'h37;
        4:  ins[6:0] = 7'h17;
        5:  ins[6:0] = 7'h63;
        6:  ins[6:0] = 7'h6F;
        7:  ins[6:0] = 7'h33;
        8:  ins[6:0] = 7'h67;
        9:  ins[6:0] = 7'h73;
        default: ;
      endcase
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_INSTR  = ins;
      IN_PC     = $urandom();
      OUT_READY = ($urandom_range(0, 2) != 0);
      FLUSH     = ($urandom_range(0, 31) == 0);
      RESET     = ($urandom_range(0, 127) == 0);
      tick();
    end
    RESET = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    tick(); tick(); tick();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
